apb_bus_arbiter: RTL
====================

# apb_bus_arbiter

APB master front end that lets two bus requesters (core load/store port and a DMA/test port) share one APB peripheral bus. It arbitrates round-robin, decodes the address to one `PSEL` per peripheral slot (GPIO, UART, timer, …), sequences the APB SETUP/ACCESS phases, and returns read data, completion and error to the granted requester. Sits between the requesters and the peripheral slaves.

## Interface
- `NUM_SLV`, 4: number of peripheral slots; slot index = `PADDR[15:12]`.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 16: max ACCESS cycles without `PREADY` before abort; ≥2.
- `PCLK`  in  1: single clock, rising edge.
- `PRESET`  in  1: reset, synchronous, active-high.
- `req`  in  [1:0]: request level per requester; held until `done` sampled.
- `addr`  in  [1:0][ADDR_W-1:0]: request address.
- `write`  in  [1:0]: 1 = write, 0 = read.
- `wdata`  in  [1:0][31:0]: write data.
- `done`  out  [1:0]: one-cycle completion pulse to the served requester.
- `err`  out  [1:0]: valid with `done`; decode error or timeout.
- `rdata`  out  [31:0]: read data, valid with `done`; shared by both requesters.
- `PADDR`  out  ADDR_W: APB address.
- `PWRITE`  out  1: APB direction.
- `PWDATA`  out  32: APB write data.
- `PENABLE`  out  1: APB access phase.
- `PSEL`  out  [NUM_SLV-1:0]: one-hot slave select.
- `PRDATA`  in  [NUM_SLV-1:0][31:0]: per-slave read data.
- `PREADY`  in  [NUM_SLV-1:0]: per-slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `req` high, grant one and latch its `addr`/`write`/`wdata` plus decoded slot index. Slot < `NUM_SLV` → SETUP; otherwise → RESP with error, no bus cycle.
- Round-robin: priority pointer resets to requester 0; after a grant the pointer moves to the other requester. Both requesting → pointer holder wins; one requesting → it wins regardless of pointer.
- SETUP: `PSEL[slot]`=1, `PENABLE`=0, `PADDR`/`PWRITE`/`PWDATA` from latched request → ACCESS.
- ACCESS: `PSEL[slot]`=1, `PENABLE`=1, address/data stable. Only `PREADY[slot]` is observed. On `PREADY[slot]`=1, capture `PRDATA[slot]` into `rdata` (reads only; writes load 0) and go to RESP with `err`=0. Timeout counter counts ACCESS cycles; when it reaches `TIMEOUT` without ready → RESP with `err`=1, `rdata`=0.
- RESP: `done[g]`=1 and `err[g]` for granted requester g; all `PSEL`/`PENABLE` 0; → IDLE. No grant is made in RESP.
- Requester contract: drop `req` on the edge where `done`=1 is sampled, so it is already low in the following IDLE cycle. Request fields are latched, so they may change after grant.
- `PADDR`/`PWRITE`/`PWDATA` hold their last values outside transfers; `PSEL`/`PENABLE` are 0 in IDLE and RESP.

## Timing
- Reset (synchronous, next edge with `PRESET`=1): state IDLE, `PSEL`=0, `PENABLE`=0, `PADDR`=0, `PWRITE`=0, `PWDATA`=0, `done`=0, `err`=0, `rdata`=0, pointer=0, timeout counter=0. Reset during SETUP/ACCESS/RESP drops the transfer; no `done` is issued.
- All outputs are registered.
- Latency (cycle 0 = IDLE with `req`): SETUP at 1, ACCESS from 2, RESP one cycle after the ACCESS cycle in which ready is sampled. A slave with registered `PREADY` (ready in 2nd ACCESS cycle) gives `done` at cycle 4.
- Decode error: `done`+`err` at cycle 1.
- Timeout: RESP in the cycle after the `TIMEOUT`-th ACCESS cycle.
- Back-to-back: the next grant occurs in the IDLE cycle after RESP; minimum 4 cycles per zero-wait transfer.
- `PREADY` of non-selected slaves and any `PREADY` outside ACCESS are ignored.

## Structure
- Package `apb_arb_pkg`: state enum, `SLV_SEL_LSB`=12, `SLV_SEL_W`=4, requester count constant 2.
- Sub-module `rr_arbiter_2`: two requests plus pointer in, one-hot grant out, pointer update on grant enable. FSM, decode and datapath live in the top.

## Test plan
- Requester 0 writes 0x0000_00A5 to 0x0000_1004 (slot 1). Expect `PSEL`=4'b0010 at cycle 1, `PENABLE` at cycle 2; slave ready at cycle 3; `done[0]`=1, `err[0]`=0 at cycle 4.
- Requester 1 reads 0x0000_0008 (slot 0) and the slave returns 0x0000_003C. Expect `rdata`=0x3C with `done[1]`=1 and `err[1]`=0.
- Both requesters assert in the same cycle, repeatedly, for 4 transfers. Expect grant order 0,1,0,1 and never two `done` bits high at once.
- Address 0x0000_7000 (slot 7 ≥ `NUM_SLV`). Expect no `PSEL` activity and `done`+`err`=1 at cycle 1.
- Slave never raises ready, `TIMEOUT`=16. Expect ACCESS held 16 cycles, then `done`+`err`=1 and `rdata`=0; the next request proceeds normally.
- `PRESET` pulsed during ACCESS. Expect `PSEL`/`PENABLE`=0 next cycle, no `done`, and pointer back to requester 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB bus arbiter.
package apb_arb_pkg;

    // Number of bus requesters (core load/store port and DMA/test port).
    localparam int unsigned NUM_REQ = 2;

    // Peripheral slot index is taken from this address field.
    localparam int unsigned SLV_SEL_LSB = 12;
    localparam int unsigned SLV_SEL_W   = 4;

    // APB master sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: pointer holder wins a tie, a lone requester
// always wins, and the pointer moves to the other requester after a grant.
module rr_arbiter_2
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ptr_i,
    input  logic               gnt_en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               ptr_o
);

    // Grant selection and next pointer value.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
        ptr_o = ptr_i;
        if (gnt_en_i && (gnt_o != '0)) begin
            // Granting requester 0 hands priority to 1 and vice versa.
            ptr_o = gnt_o[0];
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// APB master front end shared by two requesters: round-robin grant, slot
// decode, SETUP/ACCESS sequencing with timeout, registered completion.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
    input  logic [NUM_REQ-1:0]              write,
    input  logic [NUM_REQ-1:0][31:0]        wdata,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic [31:0]                     rdata,
    output logic [ADDR_W-1:0]               PADDR,
    output logic                            PWRITE,
    output logic [31:0]                     PWDATA,
    output logic                            PENABLE,
    output logic [NUM_SLV-1:0]              PSEL,
    input  logic [NUM_SLV-1:0][31:0]        PRDATA,
    input  logic [NUM_SLV-1:0]              PREADY
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   gidx_q, gidx_d;
    logic [SLV_SEL_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      paddr_q, paddr_d;
    logic                   pwrite_q, pwrite_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic                   penable_q, penable_d;
    logic [NUM_SLV-1:0]     psel_q, psel_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [NUM_REQ-1:0]     gnt;
    logic                   gnt_any;
    logic                   gnt_idx;
    logic                   ptr_nxt;
    logic [SLV_SEL_W-1:0]   req_slot;
    logic                   slot_ok;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   tmo_hit;

    function automatic logic [NUM_SLV-1:0] slot_onehot(input logic [SLV_SEL_W-1:0] s);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (s == SLV_SEL_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    rr_arbiter_2 u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .gnt_en_i (state_q == ST_IDLE),
        .gnt_o    (gnt),
        .ptr_o    (ptr_nxt)
    );

    assign gnt_any  = |gnt;
    assign gnt_idx  = gnt[1];
    assign req_slot = addr[gnt_idx][SLV_SEL_LSB +: SLV_SEL_W];
    assign slot_ok  = (32'(req_slot) < NUM_SLV);
    assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT));

    // Only the latched slot's ready/read data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (slot_q == SLV_SEL_W'(i)) begin
                sel_ready = PREADY[i];
                sel_rdata = PRDATA[i];
            end
        end
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (gnt_any) state_d = slot_ok ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (sel_ready || tmo_hit) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched request.
    always_comb begin
        ptr_d     = ptr_nxt;
        gidx_d    = gidx_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        penable_d = 1'b0;
        psel_d    = '0;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    gidx_d = gnt_idx;
                    if (slot_ok) begin
                        slot_d   = req_slot;
                        paddr_d  = addr[gnt_idx];
                        pwrite_d = write[gnt_idx];
                        pwdata_d = wdata[gnt_idx];
                        psel_d   = slot_onehot(req_slot);
                    end else begin
                        // Unmapped slot: answer straight away, bus untouched.
                        done_d[gnt_idx] = 1'b1;
                        err_d[gnt_idx]  = 1'b1;
                        rdata_d         = '0;
                    end
                end
            end
            ST_SETUP: begin
                psel_d    = slot_onehot(slot_q);
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    done_d[gidx_q] = 1'b1;
                    rdata_d        = pwrite_q ? '0 : sel_rdata;
                    cnt_d          = '0;
                end else if (tmo_hit) begin
                    done_d[gidx_q] = 1'b1;
                    err_d[gidx_q]  = 1'b1;
                    rdata_d        = '0;
                    cnt_d          = '0;
                end else begin
                    psel_d    = slot_onehot(slot_q);
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ptr_q     <= 1'b0;
            gidx_q    <= 1'b0;
            slot_q    <= '0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule
